// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 15-entry register bank: pipeline writeback has
// fixed priority, multicycle writes are queued in a small squashable FIFO.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        P_WE,
    input  logic [3:0]  P_A,
    input  logic [31:0] P_WD,
    input  logic        M_VALID,
    input  logic [3:0]  M_A,
    input  logic [31:0] M_WD,
    output logic        M_READY,
    output logic        WE3,
    output logic [3:0]  A3,
    output logic [31:0] WD3,
    output logic [14:0] PENDING,
    output logic        STALL,
    output logic        DROP
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [7:0]  LIMIT    = 8'(STARVE_LIMIT);

    // Handshake: a multicycle write transfers on a posedge where M_VALID and
    // M_READY are both high; M_READY depends only on the current fill level.
    logic [3:0]  fifo_a [DEPTH];
    logic [31:0] fifo_d [DEPTH];
    logic        fifo_v [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [7:0]    wait_cnt, wait_next;

    logic head_v, p_wr, m_pop, skip, deq, m_acc, push, m_drop;

    // Slots squashed by a pipeline write stay in the ring with valid=0 and
    // are retired at the head without using the port.
    always_comb begin
        head_v  = fifo_v[rd_ptr];
        p_wr    = P_WE && (P_A != 4'hF);
        m_pop   = !P_WE && head_v;
        skip    = !head_v && (count != '0);
        deq     = m_pop || skip;
        M_READY = (count != CNT_FULL);
        m_acc   = M_VALID && M_READY;
        push    = m_acc && (M_A != 4'hF);
        m_drop  = m_acc && (M_A == 4'hF);
        wait_next = wait_cnt;
        if (!head_v || m_pop)
            wait_next = '0;
        else if (P_WE && wait_cnt != LIMIT)
            wait_next = wait_cnt + 8'd1;
    end

    always_comb begin
        PENDING = '0;
        for (int r = 0; r < 15; r++)
            for (int i = 0; i < DEPTH; i++)
                if (fifo_v[i] && fifo_a[i] == 4'(r))
                    PENDING[r] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_v[i] <= 1'b0;
                fifo_a[i] <= '0;
                fifo_d[i] <= '0;
            end
        end else begin
            // Later assignments win: squash, then retire head, then push.
            for (int i = 0; i < DEPTH; i++)
                if (p_wr && fifo_a[i] == P_A)
                    fifo_v[i] <= 1'b0;
            if (deq) begin
                fifo_v[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + 1'b1;
            end
            if (push) begin
                fifo_v[wr_ptr] <= 1'b1;
                fifo_a[wr_ptr] <= M_A;
                fifo_d[wr_ptr] <= M_WD;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            case ({push, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            wait_cnt <= wait_next;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            WE3   <= 1'b0;
            A3    <= '0;
            WD3   <= '0;
            STALL <= 1'b0;
            DROP  <= 1'b0;
        end else begin
            WE3   <= p_wr || m_pop;
            STALL <= (wait_next == LIMIT);
            DROP  <= (P_WE && P_A == 4'hF) || m_drop;
            if (p_wr) begin
                A3  <= P_A;
                WD3 <= P_WD;
            end else if (m_pop) begin
                A3  <= fifo_a[rd_ptr];
                WD3 <= fifo_d[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter: one table of per-cycle
// stimulus with expected post-edge outputs, plus an async reset sequence.
module tb_regfile_wb_arbiter;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        P_WE;
    logic [3:0]  P_A;
    logic [31:0] P_WD;
    logic        M_VALID;
    logic [3:0]  M_A;
    logic [31:0] M_WD;
    logic        M_READY;
    logic        WE3;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic [14:0] PENDING;
    logic        STALL;
    logic        DROP;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .P_WE(P_WE), .P_A(P_A), .P_WD(P_WD),
        .M_VALID(M_VALID), .M_A(M_A), .M_WD(M_WD), .M_READY(M_READY),
        .WE3(WE3), .A3(A3), .WD3(WD3),
        .PENDING(PENDING), .STALL(STALL), .DROP(DROP)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        p_we;
        logic [3:0]  p_a;
        logic [31:0] p_wd;
        logic        m_valid;
        logic [3:0]  m_a;
        logic [31:0] m_wd;
        logic        we3;
        logic [3:0]  a3;
        logic [31:0] wd3;
        logic        rdy;
        logic [14:0] pend;
        logic        stall;
        logic        drop;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic pwe, input logic [3:0] pa, input logic [31:0] pwd,
        input logic mv, input logic [3:0] ma, input logic [31:0] mwd,
        input logic we, input logic [3:0] a, input logic [31:0] wd,
        input logic rdy, input logic [14:0] pend, input logic st, input logic dr);
        vec_t v;
        v.p_we = pwe; v.p_a = pa; v.p_wd = pwd;
        v.m_valid = mv; v.m_a = ma; v.m_wd = mwd;
        v.we3 = we; v.a3 = a; v.wd3 = wd;
        v.rdy = rdy; v.pend = pend; v.stall = st; v.drop = dr;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic pwe, input logic [3:0] pa, input logic [31:0] pwd,
                         input logic mv, input logic [3:0] ma, input logic [31:0] mwd);
        P_WE = pwe; P_A = pa; P_WD = pwd;
        M_VALID = mv; M_A = ma; M_WD = mwd;
    endtask

    task automatic check_outs(input int row, input vec_t v);
        chk("we3", row, 32'(WE3), 32'(v.we3));
        chk("a3", row, 32'(A3), 32'(v.a3));
        chk("wd3", row, WD3, v.wd3);
        chk("m_ready", row, 32'(M_READY), 32'(v.rdy));
        chk("pending", row, 32'(PENDING), 32'(v.pend));
        chk("stall", row, 32'(STALL), 32'(v.stall));
        chk("drop", row, 32'(DROP), 32'(v.drop));
    endtask

    initial begin
        // Pop latency: push r3 into an empty FIFO, written one edge later.
        vq.push_back(mk(0,0,0,        0,0,0,            0,0,0,            1,15'h0000,0,0));
        vq.push_back(mk(0,0,0,        1,3,32'hDEADBEEF, 0,0,0,            1,15'h0008,0,0));
        vq.push_back(mk(0,0,0,        0,0,0,            1,3,32'hDEADBEEF, 1,15'h0000,0,0));
        vq.push_back(mk(0,0,0,        0,0,0,            0,3,32'hDEADBEEF, 1,15'h0000,0,0));
        // Priority, fill and starvation: P_WE to r1 every cycle, push r4..r8.
        vq.push_back(mk(1,1,32'h101,  1,4,32'h44,       1,1,32'h101,      1,15'h0010,0,0));
        vq.push_back(mk(1,1,32'h102,  1,5,32'h55,       1,1,32'h102,      1,15'h0030,0,0));
        vq.push_back(mk(1,1,32'h103,  1,6,32'h66,       1,1,32'h103,      1,15'h0070,0,0));
        vq.push_back(mk(1,1,32'h104,  1,7,32'h77,       1,1,32'h104,      0,15'h00F0,0,0));
        vq.push_back(mk(1,1,32'h105,  1,8,32'h88,       1,1,32'h105,      0,15'h00F0,0,0));
        vq.push_back(mk(1,1,32'h106,  1,8,32'h88,       1,1,32'h106,      0,15'h00F0,0,0));
        vq.push_back(mk(1,1,32'h107,  1,8,32'h88,       1,1,32'h107,      0,15'h00F0,0,0));
        vq.push_back(mk(1,1,32'h108,  1,8,32'h88,       1,1,32'h108,      0,15'h00F0,0,0));
        vq.push_back(mk(1,1,32'h109,  1,8,32'h88,       1,1,32'h109,      0,15'h00F0,1,0));
        vq.push_back(mk(1,1,32'h10A,  1,8,32'h88,       1,1,32'h10A,      0,15'h00F0,1,0));
        vq.push_back(mk(0,0,0,        1,8,32'h88,       1,4,32'h44,       1,15'h00E0,0,0));
        vq.push_back(mk(0,0,0,        1,8,32'h88,       1,5,32'h55,       1,15'h01C0,0,0));
        vq.push_back(mk(0,0,0,        0,0,0,            1,6,32'h66,       1,15'h0180,0,0));
        vq.push_back(mk(0,0,0,        0,0,0,            1,7,32'h77,       1,15'h0100,0,0));
        vq.push_back(mk(0,0,0,        0,0,0,            1,8,32'h88,       1,15'h0000,0,0));
        vq.push_back(mk(0,0,0,        0,0,0,            0,8,32'h88,       1,15'h0000,0,0));
        // Squash: queue r2, r5, then a pipeline write to r2 kills the queued r2.
        vq.push_back(mk(1,1,32'h200,  1,2,32'h11,       1,1,32'h200,      1,15'h0004,0,0));
        vq.push_back(mk(1,1,32'h201,  1,5,32'h22,       1,1,32'h201,      1,15'h0024,0,0));
        vq.push_back(mk(1,2,32'h99,   0,0,0,            1,2,32'h99,       1,15'h0020,0,0));
        vq.push_back(mk(0,0,0,        0,0,0,            0,2,32'h99,       1,15'h0020,0,0));
        vq.push_back(mk(0,0,0,        0,0,0,            1,5,32'h22,       1,15'h0000,0,0));
        vq.push_back(mk(0,0,0,        0,0,0,            0,5,32'h22,       1,15'h0000,0,0));
        // r15 discard from each requester.
        vq.push_back(mk(1,15,32'h555, 0,0,0,            0,5,32'h22,       1,15'h0000,0,1));
        vq.push_back(mk(0,0,0,        0,0,0,            0,5,32'h22,       1,15'h0000,0,0));
        vq.push_back(mk(0,0,0,        1,15,32'hF00D,    0,5,32'h22,       1,15'h0000,0,1));
        vq.push_back(mk(0,0,0,        0,0,0,            0,5,32'h22,       1,15'h0000,0,0));
        // Concurrent push to the register being written by P is not squashed.
        vq.push_back(mk(1,1,32'h300,  1,1,32'h31,       1,1,32'h300,      1,15'h0002,0,0));
        vq.push_back(mk(0,0,0,        0,0,0,            1,1,32'h31,       1,15'h0000,0,0));
        vq.push_back(mk(0,0,0,        0,0,0,            0,1,32'h31,       1,15'h0000,0,0));

        RESET = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("reset_we3", -1, 32'(WE3), 32'd0);
        chk("reset_rdy", -1, 32'(M_READY), 32'd1);
        chk("reset_pend", -1, 32'(PENDING), 32'd0);
        chk("reset_stall", -1, 32'(STALL), 32'd0);
        chk("reset_drop", -1, 32'(DROP), 32'd0);

        foreach (vq[i]) begin
            drive(vq[i].p_we, vq[i].p_a, vq[i].p_wd, vq[i].m_valid, vq[i].m_a, vq[i].m_wd);
            @(posedge CLK);
            #1;
            check_outs(i, vq[i]);
        end

        // Async reset with three queued entries, asserted mid-cycle.
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 32'h400 + 32'(k), 1, 4'(9 + k), 32'h90 + 32'(k));
            @(posedge CLK);
            #1;
        end
        chk("arst_pre_pend", 0, 32'(PENDING), 32'h0E00);
        chk("arst_pre_we3", 0, 32'(WE3), 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        RESET = 1'b1;
        #1;
        chk("arst_we3", 0, 32'(WE3), 32'd0);
        chk("arst_pend", 0, 32'(PENDING), 32'd0);
        chk("arst_rdy", 0, 32'(M_READY), 32'd1);
        @(negedge CLK);
        RESET = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #1;
            chk("arst_post_we3", k, 32'(WE3), 32'd0);
            chk("arst_post_pend", k, 32'(PENDING), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
